// File: rtl/fp_add_align_stage.sv
// fp_add_align_stage
// Front end of the sequential floating-point adder. It captures two operands,
// orders them by magnitude, then shifts the smaller significand right a few
// bits per cycle. The shifted-out bits are folded into a sticky bit, which
// keeps the guard/round/sticky information intact for rounding later.
// out_valid drives the load enable of the add/sub stage registers.
module fp_add_align_stage #(
    parameter int W    = 32,
    parameter int EW   = 8,
    parameter int SW   = 23,
    parameter int STEP = 4,
    localparam int MW  = SW + 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  op_a,
    input  logic [W-1:0]  op_b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_exp,
    output logic          out_sign_l,
    output logic          out_sign_s,
    output logic [MW-1:0] out_man_l,
    output logic [MW-1:0] out_man_s,
    output logic          out_swap,
    output logic          out_special
);

    typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

    localparam logic [EW-1:0] BIG_SHIFT = EW'(SW + 3);
    localparam logic [EW-1:0] STEP_W    = EW'(STEP);

    state_t state_q, state_d;

    logic [W-1:0]  a_q, b_q;
    logic [EW-1:0] rem_q;
    logic          accept;

    logic          a_larger;
    logic [EW-1:0] exp_a, exp_b, exp_l, exp_s, eff_l, eff_s, diff;
    logic [SW-1:0] frac_l, frac_s;
    logic          sign_l, sign_s, hid_l, hid_s, special;
    logic [MW-1:0] sig_l, sig_s;

    logic [EW-1:0] k, rem_next;
    logic [MW-1:0] man_shifted;
    logic          lost;

    assign accept = in_valid && in_ready;

    // Magnitude ordering of the captured operands; a tie keeps A as the larger one
    always_comb begin
        exp_a    = a_q[W-2 -: EW];
        exp_b    = b_q[W-2 -: EW];
        a_larger = (a_q[W-2:0] >= b_q[W-2:0]);
        if (a_larger) begin
            sign_l = a_q[W-1];
            exp_l  = exp_a;
            frac_l = a_q[SW-1:0];
            sign_s = b_q[W-1];
            exp_s  = exp_b;
            frac_s = b_q[SW-1:0];
        end else begin
            sign_l = b_q[W-1];
            exp_l  = exp_b;
            frac_l = b_q[SW-1:0];
            sign_s = a_q[W-1];
            exp_s  = exp_a;
            frac_s = a_q[SW-1:0];
        end
        hid_l   = |exp_l;
        hid_s   = |exp_s;
        eff_l   = hid_l ? exp_l : EW'(1);
        eff_s   = hid_s ? exp_s : EW'(1);
        sig_l   = {hid_l, frac_l, 3'b000};
        sig_s   = {hid_s, frac_s, 3'b000};
        diff    = eff_l - eff_s;
        special = (&exp_a) | (&exp_b);
    end

    // One alignment step: shift by up to STEP bits and fold the lost bits into the sticky bit
    always_comb begin
        k    = (rem_q < STEP_W) ? rem_q : STEP_W;
        lost = 1'b0;
        for (int i = 0; i < MW; i++) begin
            if (i < int'(k)) begin
                lost = lost | out_man_s[i];
            end
        end
        man_shifted    = out_man_s >> k;
        man_shifted[0] = man_shifted[0] | lost;
        rem_next       = rem_q - k;
    end

    // Next-state sequencing through compare, the shift loop and the output handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = COMPARE;
            COMPARE: state_d = (special || diff == '0) ? DONE : SHIFT;
            SHIFT:   if (rem_next == '0) state_d = DONE;
            DONE:    if (out_valid && out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, handshake flags; in_ready stays low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_q == DONE) && !(out_valid && out_ready);
        end
    end

    // Operand capture and the result fields, which only move during COMPARE and SHIFT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q         <= '0;
            b_q         <= '0;
            rem_q       <= '0;
            out_exp     <= '0;
            out_sign_l  <= 1'b0;
            out_sign_s  <= 1'b0;
            out_man_l   <= '0;
            out_man_s   <= '0;
            out_swap    <= 1'b0;
            out_special <= 1'b0;
        end else begin
            if (accept) begin
                a_q <= op_a;
                b_q <= op_b;
            end
            case (state_q)
                COMPARE: begin
                    out_exp     <= exp_l;
                    out_sign_l  <= sign_l;
                    out_sign_s  <= sign_s;
                    out_man_l   <= sig_l;
                    out_swap    <= !a_larger;
                    out_special <= special;
                    rem_q       <= '0;
                    if (special) begin
                        out_man_s <= '0;
                    end else if (diff == '0) begin
                        out_man_s <= sig_s;
                    end else if (diff >= BIG_SHIFT) begin
                        out_man_s <= {{(MW-1){1'b0}}, |sig_s};
                    end else begin
                        out_man_s <= sig_s;
                        rem_q     <= diff;
                    end
                end
                SHIFT: begin
                    out_man_s <= man_shifted;
                    rem_q     <= rem_next;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_align_stage.sv
// Testbench for fp_add_align_stage: directed operand pairs with hand-computed
// aligned fields. A scoreboard queue holds expectations and a monitor checks
// each result as out_valid rises.
module tb_fp_add_align_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_exp;
    logic        out_sign_l, out_sign_s;
    logic [26:0] out_man_l, out_man_s;
    logic        out_swap, out_special;

    typedef struct {
        string       name;
        logic [7:0]  exp;
        logic        sign_l;
        logic        sign_s;
        logic [26:0] man_l;
        logic [26:0] man_s;
        logic        swap;
        logic        special;
        int          lat;
        int          issue;
    } expect_t;

    expect_t sb[$];
    int      cyc = 0;
    int      checks = 0;
    int      failures = 0;

    fp_add_align_stage #(.W(32), .EW(8), .SW(23), .STEP(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op_a        (op_a),
        .op_b        (op_b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_exp     (out_exp),
        .out_sign_l  (out_sign_l),
        .out_sign_s  (out_sign_s),
        .out_man_l   (out_man_l),
        .out_man_s   (out_man_s),
        .out_swap    (out_swap),
        .out_special (out_special)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    // Issue one operand pair at a negedge and queue its expected result
    task automatic applyStimulus(input string name, input logic [31:0] a, input logic [31:0] b,
                                 input logic [7:0] e, input logic sl, input logic ss,
                                 input logic [26:0] ml, input logic [26:0] ms,
                                 input logic sw, input logic sp, input int lat);
        expect_t x;
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput({name, ".ready_timeout"}, 32'd0, 32'd1);
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        x = '{name: name, exp: e, sign_l: sl, sign_s: ss, man_l: ml, man_s: ms,
              swap: sw, special: sp, lat: lat, issue: cyc + 1};
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Wait, bounded, until the scoreboard drains and the stage is idle again
    task automatic waitIdle(input string name);
        int n = 0;
        while (!(sb.size() == 0 && !out_valid && in_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) checkOutput({name, ".done_timeout"}, 32'd0, 32'd1);
    endtask

    // Monitor: compare every field and the latency when a result first appears
    initial begin
        logic prev_valid;
        expect_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (out_valid && !prev_valid) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    checkOutput({e.name, ".exp"},     32'(out_exp),     32'(e.exp));
                    checkOutput({e.name, ".sign_l"},  32'(out_sign_l),  32'(e.sign_l));
                    checkOutput({e.name, ".sign_s"},  32'(out_sign_s),  32'(e.sign_s));
                    checkOutput({e.name, ".man_l"},   32'(out_man_l),   32'(e.man_l));
                    checkOutput({e.name, ".man_s"},   32'(out_man_s),   32'(e.man_s));
                    checkOutput({e.name, ".swap"},    32'(out_swap),    32'(e.swap));
                    checkOutput({e.name, ".special"}, 32'(out_special), 32'(e.special));
                    checkOutput({e.name, ".latency"}, 32'(cyc - e.issue), 32'(e.lat));
                end
            end
            prev_valid = out_valid;
        end
    end

    // Directed sequence: reset, alignment cases, backpressure, reset abort
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        op_a      = '0;
        op_b      = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset.in_ready",  32'(in_ready),  32'd0);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.man_s",     32'(out_man_s), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("release.in_ready", 32'(in_ready), 32'd1);

        applyStimulus("d1",      32'h40000000, 32'h3F800000, 8'h80, 0, 0, 27'h4000000, 27'h2000000, 0, 0, 3);
        waitIdle("d1");
        applyStimulus("d1swap",  32'h3F800000, 32'h40000000, 8'h80, 0, 0, 27'h4000000, 27'h2000000, 1, 0, 3);
        waitIdle("d1swap");
        applyStimulus("equal",   32'h3F800000, 32'h3F800000, 8'h7F, 0, 0, 27'h4000000, 27'h4000000, 0, 0, 2);
        waitIdle("equal");
        applyStimulus("d31",     32'h4F000000, 32'h3F800000, 8'h9E, 0, 0, 27'h4000000, 27'h0000001, 0, 0, 3);
        waitIdle("d31");
        applyStimulus("d5",      32'h42000000, 32'h3F800001, 8'h84, 0, 0, 27'h4000000, 27'h0200001, 0, 0, 4);
        waitIdle("d5");
        applyStimulus("special", 32'h7F800000, 32'h3F800000, 8'hFF, 0, 0, 27'h4000000, 27'h0000000, 0, 1, 2);
        waitIdle("special");
        applyStimulus("neg",     32'hC0000000, 32'h3F800000, 8'h80, 1, 0, 27'h4000000, 27'h2000000, 0, 0, 3);
        waitIdle("neg");
        applyStimulus("negswap", 32'h3F800000, 32'hC1000000, 8'h82, 1, 0, 27'h4000000, 27'h0800000, 1, 0, 3);
        waitIdle("negswap");
        applyStimulus("d4",      32'h41800000, 32'h3F800000, 8'h83, 0, 0, 27'h4000000, 27'h0400000, 0, 0, 3);
        waitIdle("d4");
        applyStimulus("d25",     32'h4C000000, 32'h3FC00000, 8'h98, 0, 0, 27'h4000000, 27'h0000003, 0, 0, 9);
        waitIdle("d25");
        applyStimulus("d26",     32'h4C800000, 32'h3FC00000, 8'h99, 0, 0, 27'h4000000, 27'h0000001, 0, 0, 3);
        waitIdle("d26");
        applyStimulus("denorm",  32'h00800000, 32'h00000001, 8'h01, 0, 0, 27'h4000000, 27'h0000008, 0, 0, 2);
        waitIdle("denorm");

        // Backpressure: result must hold while out_ready is low
        out_ready = 1'b0;
        applyStimulus("stall", 32'h40000000, 32'h3F800000, 8'h80, 0, 0, 27'h4000000, 27'h2000000, 0, 0, 3);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) checkOutput("stall.valid_timeout", 32'd0, 32'd1);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall.out_valid", 32'(out_valid), 32'd1);
            checkOutput("stall.in_ready",  32'(in_ready),  32'd0);
            checkOutput("stall.man_s",     32'(out_man_s), 32'h2000000);
            checkOutput("stall.exp",       32'(out_exp),   32'h80);
        end
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("release.out_valid", 32'(out_valid), 32'd0);
        checkOutput("release.in_ready2", 32'(in_ready),  32'd1);

        // Reset in the middle of the d=5 shift sequence
        applyStimulus("abort", 32'h42000000, 32'h3F800001, 8'h84, 0, 0, 27'h4000000, 27'h0200001, 0, 0, 4);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort.in_ready",  32'(in_ready),  32'd0);
        checkOutput("abort.man_s",     32'(out_man_s), 32'd0);
        checkOutput("abort.man_l",     32'(out_man_l), 32'd0);
        checkOutput("abort.exp",       32'(out_exp),   32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("abort.ready_after", 32'(in_ready), 32'd1);
        applyStimulus("after_abort", 32'h40000000, 32'h3F800000, 8'h80, 0, 0, 27'h4000000, 27'h2000000, 0, 0, 3);
        waitIdle("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Overall watchdog so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
